// File: rtl/counter_pkg.sv
// Shared types for the parametrised up/down counter family.
package counter_pkg;

  typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e;
  typedef enum logic {DIR_DOWN, DIR_UP} cnt_dir_e;

endpackage

// File: rtl/counter_prescaler.sv
// Step prescaler for updown_counter_param; built only when CNT_PRESCALE_EN is defined.
// Emits one tick every (div+1) enabled cycles; clr restarts the spacing.
`ifdef CNT_PRESCALE_EN
module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_adv;
  logic                  w_hit;

  assign w_adv = en & ~clr;
  assign w_hit = (r_presc == div);
  assign tick  = w_adv & w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (w_adv) begin
      // Wrap back to zero on the terminal value so div=0 ticks every cycle
      r_presc <= w_hit ? '0 : r_presc + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate, load, terminal-count pulse and sticky overflow.
// Optional step prescaler enabled by defining CNT_PRESCALE_EN.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clr_ovf,
  input  logic [PRESCALE_W-1:0] presc_div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf_sticky
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_step;
  logic             w_boundary;
  logic             w_ovf_nxt;
  cnt_dir_e         w_dir;
  cnt_mode_e        w_mode;

  assign w_dir  = cnt_dir_e'(dir);
  assign w_mode = cnt_mode_e'(mode);

`ifdef CNT_PRESCALE_EN
  logic w_tick;

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .div   (presc_div),
    .tick  (w_tick)
  );

  assign w_step = en & ~load & w_tick;
`else
  logic w_unused_presc;

  assign w_unused_presc = ^presc_div;
  assign w_step         = en & ~load;
`endif

  always_comb begin
    w_boundary  = 1'b0;
    w_count_nxt = r_count;
    if (w_step) begin
      // ">=" on the up side catches a limit lowered below the current count
      w_boundary = (w_dir == DIR_UP) ? (r_count >= limit) : (r_count == '0);
    end
    if (load) begin
      w_count_nxt = (load_val > limit) ? limit : load_val;
    end else if (w_step) begin
      if (w_boundary) begin
        if (w_mode == MODE_WRAP) begin
          w_count_nxt = (w_dir == DIR_UP) ? '0 : limit;
        end else begin
          w_count_nxt = (w_dir == DIR_UP) ? limit : '0;
        end
      end else begin
        w_count_nxt = (w_dir == DIR_UP) ? r_count + 1'b1 : r_count - 1'b1;
      end
    end
    w_ovf_nxt = w_boundary | (r_ovf & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RESET_VAL;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_boundary;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count      = r_count;
  assign tc         = r_tc;
  assign ovf_sticky = r_ovf;

endmodule
